// File: rtl/edge_event_window_counter.sv
// Windowed counter of single-cycle edge pulses with a registered valid/ready result.
// Optional macro EDGE_FIRST_TS_EN adds first_ts, the in-window offset of the first pulse.
module edge_event_window_counter #(
  parameter int CNT_W = 8,
  parameter int WIN_W = 16
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             enable,
  input  logic [WIN_W-1:0] window_len,
  input  logic             edge_pulse,
  output logic [CNT_W-1:0] count_out,
  output logic             count_sat,
  output logic             count_valid,
  input  logic             count_ready,
  output logic             overrun,
`ifdef EDGE_FIRST_TS_EN
  output logic [WIN_W-1:0] first_ts,
`endif
  output logic             busy
);

  typedef enum logic {IDLE, COUNT} state_t;

  localparam logic [CNT_W-1:0] CMAX = '1;
  localparam logic [WIN_W-1:0] ONE  = {{(WIN_W-1){1'b0}}, 1'b1};

  state_t           state_q, state_d;
  logic [WIN_W-1:0] len_q, len_d;
  logic [WIN_W-1:0] win_q, win_d;
  logic [CNT_W-1:0] acc_q, acc_d;
  logic             sat_q, sat_d;
  logic [CNT_W-1:0] out_q, out_d;
  logic             osat_q, osat_d;
  logic             valid_q, valid_d;
  logic             ovr_q, ovr_d;

  logic             hit;
  logic             win_end;
  logic [WIN_W-1:0] len_start;
  logic [CNT_W-1:0] acc_nx;
  logic             sat_nx;

  assign hit       = edge_pulse && (state_q == COUNT);
  assign win_end   = (state_q == COUNT) && (win_q == len_q - ONE);
  assign len_start = (window_len == '0) ? ONE : window_len;
  assign acc_nx    = (hit && acc_q != CMAX) ? acc_q + 1'b1 : acc_q;
  assign sat_nx    = sat_q | (hit && acc_q == CMAX);

  always_comb begin
    state_d = state_q;
    len_d   = len_q;
    win_d   = win_q;
    acc_d   = acc_q;
    sat_d   = sat_q;
    unique case (state_q)
      IDLE: begin
        if (enable) begin
          state_d = COUNT;
          len_d   = len_start;
          win_d   = '0;
          acc_d   = '0;
          sat_d   = 1'b0;
        end
      end
      COUNT: begin
        if (win_end) begin
          state_d = enable ? COUNT : IDLE;
          len_d   = len_start;
          win_d   = '0;
          acc_d   = '0;
          sat_d   = 1'b0;
        end else begin
          win_d = win_q + ONE;
          acc_d = acc_nx;
          sat_d = sat_nx;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // A new result always wins; losing an unconsumed one is flagged.
  always_comb begin
    out_d   = out_q;
    osat_d  = osat_q;
    valid_d = valid_q & ~count_ready;
    ovr_d   = ovr_q;
    if (win_end) begin
      out_d   = acc_nx;
      osat_d  = sat_nx;
      valid_d = 1'b1;
      ovr_d   = ovr_q | (valid_q & ~count_ready);
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      len_q   <= '0;
      win_q   <= '0;
      acc_q   <= '0;
      sat_q   <= 1'b0;
      out_q   <= '0;
      osat_q  <= 1'b0;
      valid_q <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      len_q   <= len_d;
      win_q   <= win_d;
      acc_q   <= acc_d;
      sat_q   <= sat_d;
      out_q   <= out_d;
      osat_q  <= osat_d;
      valid_q <= valid_d;
      ovr_q   <= ovr_d;
    end
  end

`ifdef EDGE_FIRST_TS_EN
  logic [WIN_W-1:0] first_q, first_d;
  logic             seen_q, seen_d;
  logic [WIN_W-1:0] fts_q, fts_d;
  logic [WIN_W-1:0] fts_nx;

  assign fts_nx = seen_q ? first_q : (hit ? win_q : '1);

  always_comb begin
    first_d = first_q;
    seen_d  = seen_q;
    fts_d   = fts_q;
    if (win_end || state_q == IDLE) begin
      first_d = '0;
      seen_d  = 1'b0;
    end else if (hit && !seen_q) begin
      first_d = win_q;
      seen_d  = 1'b1;
    end
    if (win_end) fts_d = fts_nx;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      first_q <= '0;
      seen_q  <= 1'b0;
      fts_q   <= '0;
    end else begin
      first_q <= first_d;
      seen_q  <= seen_d;
      fts_q   <= fts_d;
    end
  end

  assign first_ts = fts_q;
`endif

  assign count_out   = out_q;
  assign count_sat   = osat_q;
  assign count_valid = valid_q;
  assign overrun     = ovr_q;
  assign busy        = (state_q == COUNT);

endmodule

// File: tb/tb_edge_event_window_counter.sv
// Directed bench for edge_event_window_counter.
// Inputs change 1ns after each rising edge; outputs are checked there too.
module tb_edge_event_window_counter;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        enable = 1'b0;
  logic [15:0] window_len = 16'd0;
  logic        edge_pulse = 1'b0;
  logic [7:0]  count_out;
  logic        count_sat;
  logic        count_valid;
  logic        count_ready = 1'b0;
  logic        overrun;
  logic        busy;
`ifdef EDGE_FIRST_TS_EN
  logic [15:0] first_ts;
`endif

  int n_run = 0;
  int n_fail = 0;

  edge_event_window_counter #(.CNT_W(8), .WIN_W(16)) dut (
    .clock(clock),
    .reset(reset),
    .enable(enable),
    .window_len(window_len),
    .edge_pulse(edge_pulse),
    .count_out(count_out),
    .count_sat(count_sat),
    .count_valid(count_valid),
    .count_ready(count_ready),
    .overrun(overrun),
`ifdef EDGE_FIRST_TS_EN
    .first_ts(first_ts),
`endif
    .busy(busy)
  );

  always #5 clock = ~clock;

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    enable = 1'b0;
    edge_pulse = 1'b0;
    count_ready = 1'b0;
    reset = 1'b0;
    step();
    step();
    reset = 1'b1;
    step();
  endtask

  task automatic test_reset();
    reset = 1'b0;
    enable = 1'b1;
    window_len = 16'd2;
    count_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      edge_pulse = i[0];
      step();
      n_run++;
      if (count_out !== 8'd0 || count_valid !== 1'b0 ||
          overrun !== 1'b0 || busy !== 1'b0) begin
        n_fail++;
        $display("FAIL reset_hold cyc%0d: out=%0d v=%b ovr=%b busy=%b want 0 0 0 0",
                 i, count_out, count_valid, overrun, busy);
      end
    end
    do_reset();
  endtask

  task automatic test_basic();
    window_len = 16'd10;
    count_ready = 1'b1;
    enable = 1'b1;
    edge_pulse = 1'b0;
    step();
    n_run++;
    if (busy !== 1'b1) begin
      n_fail++;
      $display("FAIL basic_busy: busy=%b want 1", busy);
    end
    for (int c = 0; c < 10; c++) begin
      edge_pulse = (c == 2 || c == 5 || c == 9);
      enable = (c < 9);
      window_len = (c < 4) ? 16'd10 : 16'd3;
      step();
      if (c == 8) begin
        n_run++;
        if (count_valid !== 1'b0) begin
          n_fail++;
          $display("FAIL basic_early_valid: v=%b want 0", count_valid);
        end
      end
    end
    edge_pulse = 1'b0;
    n_run++;
    if (count_out !== 8'd3 || count_sat !== 1'b0 || count_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL basic_result: out=%0d sat=%b v=%b want 3 0 1",
               count_out, count_sat, count_valid);
    end
`ifdef EDGE_FIRST_TS_EN
    n_run++;
    if (first_ts !== 16'd2) begin
      n_fail++;
      $display("FAIL basic_first_ts: got %0d want 2", first_ts);
    end
`endif
    n_run++;
    if (busy !== 1'b0) begin
      n_fail++;
      $display("FAIL basic_idle: busy=%b want 0", busy);
    end
    step();
    n_run++;
    if (count_valid !== 1'b0 || count_out !== 8'd3) begin
      n_fail++;
      $display("FAIL basic_consume: v=%b out=%0d want 0 3", count_valid, count_out);
    end
  endtask

  task automatic test_saturation();
    do_reset();
    window_len = 16'd400;
    count_ready = 1'b1;
    enable = 1'b1;
    step();
    enable = 1'b0;
    for (int c = 0; c < 400; c++) begin
      edge_pulse = (c < 300);
      step();
    end
    edge_pulse = 1'b0;
    n_run++;
    if (count_out !== 8'd255 || count_sat !== 1'b1 || count_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL saturation: out=%0d sat=%b v=%b want 255 1 1",
               count_out, count_sat, count_valid);
    end
    step();
  endtask

  task automatic test_back_to_back();
    do_reset();
    window_len = 16'd8;
    count_ready = 1'b0;
    enable = 1'b1;
    step();
    for (int c = 0; c < 8; c++) begin
      edge_pulse = (c < 5);
      step();
    end
    n_run++;
    if (count_out !== 8'd5 || count_valid !== 1'b1 || overrun !== 1'b0) begin
      n_fail++;
      $display("FAIL bp_first: out=%0d v=%b ovr=%b want 5 1 0",
               count_out, count_valid, overrun);
    end
    for (int c = 0; c < 8; c++) begin
      edge_pulse = (c < 7);
      enable = (c < 7);
      step();
      if (c == 4) begin
        n_run++;
        if (count_out !== 8'd5 || count_valid !== 1'b1) begin
          n_fail++;
          $display("FAIL bp_hold: out=%0d v=%b want 5 1", count_out, count_valid);
        end
      end
    end
    edge_pulse = 1'b0;
    n_run++;
    if (count_out !== 8'd7 || count_valid !== 1'b1 || overrun !== 1'b1) begin
      n_fail++;
      $display("FAIL bp_overrun: out=%0d v=%b ovr=%b want 7 1 1",
               count_out, count_valid, overrun);
    end
    count_ready = 1'b1;
    step();
    n_run++;
    if (count_valid !== 1'b0 || overrun !== 1'b1) begin
      n_fail++;
      $display("FAIL bp_release: v=%b ovr=%b want 0 1", count_valid, overrun);
    end
  endtask

  task automatic test_enable_drop();
    do_reset();
    window_len = 16'd10;
    count_ready = 1'b1;
    enable = 1'b1;
    step();
    for (int c = 0; c < 10; c++) begin
      enable = (c < 4);
      edge_pulse = (c == 1 || c == 6);
      if (c == 5) begin
        n_run++;
        if (busy !== 1'b1) begin
          n_fail++;
          $display("FAIL drop_busy: busy=%b want 1", busy);
        end
      end
      step();
    end
    edge_pulse = 1'b0;
    n_run++;
    if (count_out !== 8'd2 || count_valid !== 1'b1 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL drop_result: out=%0d v=%b busy=%b want 2 1 0",
               count_out, count_valid, busy);
    end
    for (int i = 0; i < 15; i++) begin
      edge_pulse = i[0];
      step();
    end
    edge_pulse = 1'b0;
    n_run++;
    if (count_valid !== 1'b0 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL drop_quiet: v=%b busy=%b want 0 0", count_valid, busy);
    end
  endtask

  task automatic test_len_zero_reset();
    do_reset();
    window_len = 16'd0;
    count_ready = 1'b1;
    edge_pulse = 1'b1;
    enable = 1'b1;
    step();
    n_run++;
    if (count_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL len0_entry: v=%b want 0", count_valid);
    end
    for (int i = 0; i < 4; i++) begin
      step();
      n_run++;
      if (count_out !== 8'd1 || count_valid !== 1'b1) begin
        n_fail++;
        $display("FAIL len0_cyc%0d: out=%0d v=%b want 1 1", i, count_out, count_valid);
      end
`ifdef EDGE_FIRST_TS_EN
      n_run++;
      if (first_ts !== 16'd0) begin
        n_fail++;
        $display("FAIL len0_first_ts: got %0d want 0", first_ts);
      end
`endif
    end
    #2;
    reset = 1'b0;
    #1;
    n_run++;
    if (count_out !== 8'd0 || count_valid !== 1'b0 || busy !== 1'b0 || overrun !== 1'b0) begin
      n_fail++;
      $display("FAIL async_reset: out=%0d v=%b busy=%b ovr=%b want 0 0 0 0",
               count_out, count_valid, busy, overrun);
    end
    enable = 1'b0;
    step();
    reset = 1'b1;
    for (int i = 0; i < 5; i++) step();
    n_run++;
    if (count_valid !== 1'b0 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL post_reset_idle: v=%b busy=%b want 0 0", count_valid, busy);
    end
    edge_pulse = 1'b0;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_saturation();
    test_back_to_back();
    test_enable_drop();
    test_len_zero_reset();
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
